// File: rtl/or1200_bpred_resolve.sv
// rtl/or1200_bpred_resolve.sv - branch prediction resolve/redirect unit; optional stats via OR1200_BPRED_STATS_EN
module or1200_bpred_resolve #(
  parameter int dw    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_advance,
  input  logic [2:0]    id_branch_op,
  input  logic [31:0]   id_pc,
  input  logic [dw-1:2] id_branch_addrtarget,
  input  logic          predict_taken,
  input  logic          ex_resolve,
  input  logic          ex_branch_taken,
  input  logic [dw-1:2] ex_branch_addrtarget,
  input  logic          icpu_ack_i,
  output logic          flush_o,
  output logic          redirect_valid_o,
  output logic [31:0]   redirect_adr_o,
  output logic          stall_o,
  output logic [31:0]   branch_cnt_o,
  output logic [31:0]   mispredict_cnt_o
);

  localparam logic [2:0] BRANCHOP_NOP = 3'd0;
  localparam logic [2:0] BRANCHOP_RFE = 3'd6;
  localparam int         TW = dw - 2;
  localparam int         EW = 1 + TW + 32;

  typedef enum logic {ST_IDLE, ST_REDIRECT} state_t;

  // Entry layout: {prediction, predicted target, fall-through pc}
  logic [EW-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]    count_q, count_d;
  state_t        state_q, state_d;
  logic          flush_q, flush_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   radr_q, radr_d;

  logic          pop, push, mispredict, head_pred, push_pred;
  logic [TW-1:0] head_tgt;
  logic [31:0]   head_fall, fix_adr;
  logic [1:0]    cnt_after_pop;
  logic [EW-1:0] new_entry;

  // Resolve decode: head compare, corrected address and push/pop qualification
  always_comb begin
    head_pred     = e0_q[EW-1];
    head_tgt      = e0_q[EW-2 -: TW];
    head_fall     = e0_q[31:0];
    pop           = (state_q == ST_IDLE) && ex_resolve && (count_q != 2'd0);
    mispredict    = pop && ((ex_branch_taken != head_pred) ||
                            (ex_branch_taken && (ex_branch_addrtarget != head_tgt)));
    fix_adr       = ex_branch_taken ? 32'({ex_branch_addrtarget, 2'b00})
                                    : {head_fall[31:2], 2'b00};
    cnt_after_pop = count_q - {1'b0, pop};
    push          = (state_q == ST_IDLE) && id_advance && (id_branch_op != BRANCHOP_NOP) &&
                    (cnt_after_pop != 2'(DEPTH));
    // RFE always redirects, so it is recorded as predicted-taken
    push_pred     = (id_branch_op == BRANCHOP_RFE) ? 1'b1 : predict_taken;
    new_entry     = {push_pred, id_branch_addrtarget, id_pc + 32'd8};
    stall_o       = (state_q == ST_REDIRECT) || ((count_q == 2'(DEPTH)) && !pop);
  end

  // FIFO next state: shift out on pop, then append behind the survivors; mispredict empties it
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (mispredict) begin
      count_d = 2'd0;
    end else begin
      if (pop) e0_d = e1_q;
      if (push) begin
        if (cnt_after_pop == 2'd0) e0_d = new_entry;
        else                       e1_d = new_entry;
      end
      count_d = cnt_after_pop + {1'b0, push};
    end
  end

  // Redirect FSM next state and its registered outputs
  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    rvalid_d = rvalid_q;
    radr_d   = radr_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d  = ST_REDIRECT;
          flush_d  = 1'b1;
          rvalid_d = 1'b1;
          radr_d   = fix_adr;
        end
      end
      ST_REDIRECT: begin
        if (icpu_ack_i) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      flush_q  <= 1'b0;
      rvalid_q <= 1'b0;
      radr_q   <= 32'd0;
      count_q  <= 2'd0;
      e0_q     <= '0;
      e1_q     <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      rvalid_q <= rvalid_d;
      radr_q   <= radr_d;
      count_q  <= count_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = rvalid_q;
  assign redirect_adr_o   = radr_q;

`ifdef OR1200_BPRED_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;

  // Saturating resolved-branch and mispredict counters
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (pop && (branch_cnt_q != 32'hFFFFFFFF))            branch_cnt_d     = branch_cnt_q + 32'd1;
    if (mispredict && (mispredict_cnt_q != 32'hFFFFFFFF)) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  assign branch_cnt_o     = 32'd0;
  assign mispredict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_or1200_bpred_resolve.sv
// tb/tb_or1200_bpred_resolve.sv - self-checking bench for or1200_bpred_resolve
module tb_or1200_bpred_resolve;

`ifdef OR1200_BPRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_advance, predict_taken, ex_resolve, ex_branch_taken, icpu_ack_i;
  logic [2:0]  id_branch_op;
  logic [31:0] id_pc;
  logic [31:2] id_branch_addrtarget, ex_branch_addrtarget;
  logic        flush_o, redirect_valid_o, stall_o;
  logic [31:0] redirect_adr_o, branch_cnt_o, mispredict_cnt_o;

  or1200_bpred_resolve #(.dw(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .id_advance(id_advance), .id_branch_op(id_branch_op), .id_pc(id_pc),
    .id_branch_addrtarget(id_branch_addrtarget), .predict_taken(predict_taken),
    .ex_resolve(ex_resolve), .ex_branch_taken(ex_branch_taken),
    .ex_branch_addrtarget(ex_branch_addrtarget), .icpu_ack_i(icpu_ack_i),
    .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_adr_o(redirect_adr_o),
    .stall_o(stall_o), .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    logic [29:0] tgt;
    logic [31:0] fall;
  } ent_t;

  ent_t        q[$];
  bit          redir, e_flush, e_valid;
  logic [31:0] e_adr, bcnt, mcnt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    redir = 0; e_flush = 0; e_valid = 0; e_adr = 0; bcnt = 0; mcnt = 0;
  endtask

  // One clock: check registered outputs, drive inputs, check stall, then advance the model
  task automatic cycle(input logic adv, input logic [2:0] op, input logic [31:0] pc,
                       input logic [29:0] tgt, input logic pr, input logic res,
                       input logic tk, input logic [29:0] xt, input logic ack);
    ent_t        h, e;
    bit          mis, m_stall;
    logic [31:0] nadr;
    @(negedge clk);
    chk("flush_o", flush_o, e_flush);
    chk("redirect_valid_o", redirect_valid_o, e_valid);
    if (e_valid) chk("redirect_adr_o", redirect_adr_o, e_adr);
    chk("branch_cnt_o", branch_cnt_o, STATS ? bcnt : 32'd0);
    chk("mispredict_cnt_o", mispredict_cnt_o, STATS ? mcnt : 32'd0);
    m_stall = redir || (q.size() == 2 && !res);
    if (m_stall) adv = 1'b0;
    id_advance = adv; id_branch_op = op; id_pc = pc; id_branch_addrtarget = tgt;
    predict_taken = pr; ex_resolve = res; ex_branch_taken = tk;
    ex_branch_addrtarget = xt; icpu_ack_i = ack;
    #1 chk("stall_o", stall_o, m_stall);
    @(posedge clk);
    e_flush = 0;
    if (redir) begin
      if (ack) begin redir = 0; e_valid = 0; end
    end else begin
      mis = 0; nadr = 0;
      if (res && q.size() > 0) begin
        h = q.pop_front();
        bcnt = sat_inc(bcnt);
        if (tk != h.pred || (tk && h.pred && xt != h.tgt)) begin
          mis = 1;
          nadr = tk ? {xt, 2'b00} : h.fall;
        end
      end
      if (mis) begin
        q.delete();
        redir = 1; e_flush = 1; e_valid = 1; e_adr = nadr;
        mcnt = sat_inc(mcnt);
      end else if (adv && op != 3'd0) begin
        e.pred = (op == 3'd6) ? 1'b1 : pr;
        e.tgt  = tgt;
        e.fall = (pc + 32'd8) & 32'hFFFFFFFC;
        q.push_back(e);
      end
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [29:0] tgt, input logic pr);
    cycle(1, 3'd1, pc, tgt, pr, 0, 0, 30'd0, 0);
  endtask

  task automatic resolve(input logic tk, input logic [29:0] xt);
    cycle(0, 3'd0, 32'd0, 30'd0, 0, 1, tk, xt, 0);
  endtask

  task automatic idle(input logic ack);
    cycle(0, 3'd0, 32'd0, 30'd0, 0, 0, 0, 30'd0, ack);
  endtask

  initial begin
    logic        ra, rr, rt, rp, rk;
    logic [2:0]  rop;
    logic [31:0] rpc;
    logic [29:0] rtg, rxt;
    rst = 1'b0;
    id_advance = 0; id_branch_op = 0; id_pc = 0; id_branch_addrtarget = 0;
    predict_taken = 0; ex_resolve = 0; ex_branch_taken = 0; ex_branch_addrtarget = 0;
    icpu_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset flush_o", flush_o, 0);
    chk("reset redirect_valid_o", redirect_valid_o, 0);
    chk("reset redirect_adr_o", redirect_adr_o, 0);
    chk("reset stall_o", stall_o, 0);
    chk("reset branch_cnt_o", branch_cnt_o, 0);
    chk("reset mispredict_cnt_o", mispredict_cnt_o, 0);
    @(negedge clk) rst = 1'b1;

    // Correct not-taken prediction
    push(32'h100, 30'h10, 0);
    resolve(0, 30'h0);
    #1;
    chk("d036 flush_o", flush_o, 0);
    chk("d036 model empty", q.size(), 0);
    chk("d036 branch_cnt_o", branch_cnt_o, STATS ? 32'd1 : 32'd0);

    // Not-taken predicted, taken resolved; ack after three cycles
    push(32'h200, 30'h55, 0);
    resolve(1, 30'h20);
    #1;
    chk("d037 flush_o", flush_o, 1);
    chk("d037 redirect_adr_o", redirect_adr_o, 32'h80);
    chk("d037 stall_o", stall_o, 1);
    idle(0);
    #1 chk("d037 flush pulse", flush_o, 0);
    idle(0);
    idle(1);
    idle(0);
    #1;
    chk("d037 redirect_valid_o", redirect_valid_o, 0);
    chk("d037 stall_o released", stall_o, 0);

    // Taken with wrong target, then taken predicted but not taken
    push(32'h300, 30'h4, 1);
    resolve(1, 30'h5);
    #1 chk("d038 target miss", redirect_adr_o, 32'h14);
    idle(1);
    push(32'h300, 30'h4, 1);
    resolve(0, 30'h0);
    #1 chk("d038 fallthrough", redirect_adr_o, 32'h308);
    idle(1);

    // RFE is stored as taken: taken with same target is correct
    cycle(1, 3'd6, 32'h400, 30'h33, 0, 0, 0, 30'd0, 0);
    resolve(1, 30'h33);
    #1 chk("rfe no flush", flush_o, 0);

    // Full FIFO stalls; push with simultaneous pop keeps occupancy
    push(32'h500, 30'h1, 0);
    push(32'h600, 30'h2, 0);
    idle(0);
    #1 chk("d039 stall full", stall_o, 1);
    cycle(1, 3'd2, 32'h700, 30'h3, 0, 1, 0, 30'd0, 0);
    #1 chk("d039 model occupancy", q.size(), 2);
    idle(0);
    #1 chk("d039 stall still full", stall_o, 1);
    resolve(0, 30'h0);
    resolve(0, 30'h0);
    resolve(1, 30'h9);
    #1 chk("d039 empty resolve ignored", flush_o, 0);

    // Fall-through wraps; reset mid-redirect clears everything immediately
    push(32'hFFFFFFFC, 30'h7, 1);
    resolve(0, 30'h0);
    #1 chk("d040 wrap", redirect_adr_o, 32'h4);
    idle(0);
    #1 rst = 1'b0;
    #1;
    chk("d041 flush_o", flush_o, 0);
    chk("d041 redirect_valid_o", redirect_valid_o, 0);
    chk("d041 redirect_adr_o", redirect_adr_o, 0);
    chk("d041 stall_o", stall_o, 0);
    chk("d041 mispredict_cnt_o", mispredict_cnt_o, 0);
    model_reset();
    @(negedge clk) rst = 1'b1;

`ifdef OR1200_BPRED_STATS_EN
    @(negedge clk);
    dut.mispredict_cnt_q = 32'hFFFFFFFF;
    mcnt = 32'hFFFFFFFF;
    push(32'h800, 30'h1, 0);
    resolve(1, 30'h2);
    #1 chk("d041 saturate", mispredict_cnt_o, 32'hFFFFFFFF);
    idle(1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ra  = $urandom_range(0, 1);
      rop = 3'($urandom_range(0, 7));
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      rtg = 30'($urandom);
      rp  = $urandom_range(0, 1);
      rr  = $urandom_range(0, 1);
      rk  = ($urandom_range(0, 2) == 0);
      if (q.size() > 0) begin
        rt  = ($urandom_range(0, 3) != 0) ? q[0].pred : ~q[0].pred;
        rxt = (rt && q[0].pred && $urandom_range(0, 3) != 0) ? q[0].tgt : 30'($urandom);
      end else begin
        rt  = $urandom_range(0, 1);
        rxt = 30'($urandom);
      end
      cycle(ra, rop, rpc, rtg, rp, rr, rt, rxt, rk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
